mem_arbiter: RTL

Round-robin arbiter that shares one single-port 16-bit memory (Hack-style RAM, 15-bit word address, 1-cycle registered read) among N requesters. Sits between the CPU/peripheral masters and the RAM. Each access runs a fixed three-state sequence: pick, issue, complete. It ends with a one-cycle ack and read data returned to the winner.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_picker.sv | 25 ++
 rtl/mem_arbiter.sv | 68 ++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and index-width helper for mem_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COMPLETE = 2'd2} state_t;
   localparam int AW_DEF = 15;
   localparam int DW_DEF = 16;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector, first set req bit at or after ptr, wrapping mod N
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);
   logic [N-1:0]  rot;
   logic [IW-1:0] low;
   logic [IW:0]   sum;
   assign any = |req;
   // rotate so ptr sits at bit 0, take the lowest set bit, then map back to a requester index
   always_comb begin
      rot = N'({req, req} >> ptr);
      low = '0;
      for (int i = N - 1; i >= 0; i--) low = rot[i] ? IW'(i) : low;
      sum = {1'b0, ptr} + {1'b0, low};
      idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port RAM among N requesters, pick/issue/complete per access
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   localparam int IW = idx_w(N)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  we,
   input  logic [N*AW-1:0] addr,
   input  logic [N*DW-1:0] wdata,
   output logic [N-1:0]  ack,
   output logic [DW-1:0] rdata,
   output logic [IW-1:0] grant,
   output logic          busy,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);
   state_t        state, nxt;
   logic          any, we_q;
   logic [IW-1:0] idx, ptr;
   if (N < 2 || N > 8) begin : g_bad_n
      $error("mem_arbiter: N must be within 2..8");
   end
   rr_picker #(.N(N), .IW(IW)) u_pick (
      .req(req),
      .ptr(ptr),
      .any(any),
      .idx(idx)
   );
   // next state: wait in IDLE for a request, then always ISSUE -> COMPLETE -> IDLE
   always_comb begin
      nxt = (state == IDLE) ? (any ? ISSUE : IDLE) : (state == ISSUE) ? COMPLETE : IDLE;
   end
   // state register; async reset aborts any access in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   end
   // capture the winner's access in IDLE, advance the round-robin pointer past it in COMPLETE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr     <= '0;
         grant   <= '0;
         we_q    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         if (state == IDLE && any) begin
            grant   <= idx;
            we_q    <= we[idx];
            m_addr  <= addr[idx*AW +: AW];
            m_wdata <= wdata[idx*DW +: DW];
         end
         if (state == COMPLETE) ptr <= (grant == IW'(N - 1)) ? '0 : grant + IW'(1);
      end
   end
   assign busy  = (state != IDLE);
   assign m_we  = (state == ISSUE) && we_q;
   assign ack   = (state == COMPLETE) ? N'(1) << grant : '0;
   assign rdata = (state == COMPLETE) ? m_rdata : '0;
endmodule
